softmax_max_sub: RTL and testbench

Row-buffered max-subtract stage for the softmax datapath. It receives a row of signed int8 scores, 8 lanes per beat, buffers the row and tracks the running maximum per lane group. It then replays the row with the group maximum subtracted from every element, so the downstream exp unit only ever sees non-positive inputs. It sits directly after the score accumulator and consumes the same lane-grouping modes as the max-finder trees.

---
 rtl/softmax_max_sub.sv | 168 ++++++++++++++++
 tb/tb_softmax_max_sub.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/softmax_max_sub.sv
// Row-buffered max-subtract stage: buffers a row of int8 beats, tracks per-group
// signed maxima, then replays the row as saturated (x - groupmax).
module softmax_max_sub #(
    parameter int unsigned LANES     = 8,
    parameter int unsigned MAX_BEATS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           seg_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*8-1:0]   in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*8-1:0]   out_data,
    output logic                 out_last,
    output logic                 row_err
);
    localparam int unsigned DW = LANES * 8;
    localparam int unsigned PW = $clog2(MAX_BEATS);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                state, state_n;
    logic [CW-1:0]         count, count_n;
    logic [PW-1:0]         rd_ptr, rd_ptr_n;
    logic [1:0]            mode_q, mode_n, mode_eff, seg_norm;
    logic                  in_ready_n, out_valid_n, out_last_n, row_err_n;
    logic                  accept, drain_hs, first_beat;

    logic [DW-1:0]         buffer [MAX_BEATS];
    logic [DW-1:0]         rd_word;
    logic signed [7:0]     gmax      [8];
    logic signed [7:0]     lane_in   [8];
    logic signed [7:0]     beat_max  [8];
    logic signed [7:0]     pair_max  [4];
    logic signed [7:0]     quad_max  [2];
    logic signed [7:0]     all_max;
    logic [8:0]            diff      [8];

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    assign accept   = in_valid && in_ready;
    assign drain_hs = out_valid && out_ready;
    assign seg_norm = (seg_mode == 2'd3) ? 2'd0 : seg_mode;
    assign mode_eff = (state == IDLE) ? seg_norm : mode_q;

    // Per-lane maximum of the lane's group within the incoming beat
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane_in[i] = in_data[8*i +: 8];
        end
        for (int p = 0; p < 4; p++) begin
            pair_max[p] = smax(lane_in[2*p], lane_in[2*p+1]);
        end
        quad_max[0] = smax(pair_max[0], pair_max[1]);
        quad_max[1] = smax(pair_max[2], pair_max[3]);
        all_max     = smax(quad_max[0], quad_max[1]);
        for (int i = 0; i < 8; i++) begin
            case (mode_eff)
                2'd2:    beat_max[i] = pair_max[i/2];
                2'd1:    beat_max[i] = quad_max[i/4];
                default: beat_max[i] = all_max;
            endcase
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n    = state;
        count_n    = count;
        rd_ptr_n   = rd_ptr;
        mode_n     = mode_q;
        out_last_n = out_last;
        row_err_n  = 1'b0;
        first_beat = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    first_beat = 1'b1;
                    mode_n     = seg_norm;
                    count_n    = CW'(1);
                    state_n    = in_last ? DRAIN : LOAD;
                    out_last_n = in_last;
                end
            end
            LOAD: begin
                if (accept) begin
                    count_n = count + CW'(1);
                    if (in_last || count_n == CW'(MAX_BEATS)) begin
                        state_n    = DRAIN;
                        row_err_n  = !in_last;
                        out_last_n = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (drain_hs) begin
                    if (out_last) begin
                        state_n    = IDLE;
                        count_n    = '0;
                        rd_ptr_n   = '0;
                        out_last_n = 1'b0;
                    end else begin
                        rd_ptr_n   = rd_ptr + PW'(1);
                        out_last_n = ({1'b0, rd_ptr_n} == count - CW'(1));
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        in_ready_n  = (state_n != DRAIN);
        out_valid_n = (state_n == DRAIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            mode_q    <= 2'd0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            row_err   <= 1'b0;
            for (int i = 0; i < 8; i++) gmax[i] <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            rd_ptr    <= rd_ptr_n;
            mode_q    <= mode_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            row_err   <= row_err_n;
            if (accept) begin
                for (int i = 0; i < 8; i++) begin
                    gmax[i] <= first_beat ? beat_max[i] : smax(gmax[i], beat_max[i]);
                end
            end
        end
    end

    // Row storage carries no reset; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[count[PW-1:0]] <= in_data;
        end
    end

    // 9-bit difference, clamped at -128 (bit8 set, bit7 clear means below -128)
    assign rd_word = buffer[rd_ptr];
    always_comb begin
        out_data = '0;
        for (int i = 0; i < 8; i++) begin
            diff[i] = {rd_word[8*i+7], rd_word[8*i +: 8]} - {gmax[i][7], gmax[i]};
            if (out_valid) begin
                out_data[8*i +: 8] = (diff[i][8] && !diff[i][7]) ? 8'h80 : diff[i][7:0];
            end
        end
    end

endmodule

// File: tb/tb_softmax_max_sub.sv
// Directed bench for softmax_max_sub: table of rows with hand-computed outputs,
// plus truncation, backpressure and mid-drain reset sequences.
module tb_softmax_max_sub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  seg_mode;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        row_err;

    int errs   = 0;
    int checks = 0;
    int rerr_cnt = 0;

    typedef struct {
        logic [1:0]  mode;
        int          n;
        bit          bp;
        logic [63:0] din [16];
        logic [63:0] exp [16];
    } vec_t;

    vec_t vecs [6];

    softmax_max_sub #(.LANES(8), .MAX_BEATS(16)) dut (
        .clk(clk), .rst_n(rst_n), .seg_mode(seg_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .row_err(row_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (row_err === 1'b1) rerr_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3,
                                       input int a4, input int a5, input int a6, input int a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Drives n beats starting at a negedge; ends at the negedge after the last accept
    task automatic send_row(input logic [1:0] mode, input int n, input logic [63:0] beats [16],
                            input bit use_last);
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
            if (!in_ready) chk("in_ready_wait", 64'(in_ready), 64'd1);
            seg_mode = (b == 0) ? mode : ~mode;
            in_data  = beats[b];
            in_last  = use_last && (b == n - 1);
            in_valid = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("latency_out_valid", 64'(out_valid), 64'd1);
    endtask

    // Drains n beats from the current negedge, checking data, last and stall stability
    task automatic recv_row(input string tag, input int n, input logic [63:0] exp [16],
                            input bit bp);
        int idx = 0;
        int t = 0;
        bit stalled = 0;
        logic [63:0] prev = '0;
        while (idx < n && t < 300) begin
            if (out_valid) begin
                chk($sformatf("%s in_ready_drain", tag), 64'(in_ready), 64'd0);
                if (stalled) chk($sformatf("%s stall_stable b%0d", tag, idx), out_data, prev);
                chk($sformatf("%s data b%0d", tag, idx), out_data, exp[idx]);
                chk($sformatf("%s last b%0d", tag, idx), 64'(out_last), 64'(idx == n - 1));
                out_ready = (bp && t < 60) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_ready) begin
                    idx++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prev = out_data;
                end
            end else begin
                chk($sformatf("%s drain_valid", tag), 64'(out_valid), 64'd1);
            end
            @(negedge clk);
            t++;
        end
        if (idx < n) chk($sformatf("%s drain_timeout", tag), 64'(idx), 64'(n));
        out_ready = 1'b0;
        chk($sformatf("%s valid_after", tag), 64'(out_valid), 64'd0);
        chk($sformatf("%s ready_after", tag), 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [63:0] tb_in [16];
        logic [63:0] tb_exp [16];
        int snap;

        // Hand-computed row table
        vecs[0].mode = 2'd0; vecs[0].n = 2; vecs[0].bp = 0;
        vecs[0].din[0] = pk(1, 2, 3, 4, 5, 6, 7, 8);
        vecs[0].din[1] = pk(0, 0, 0, 0, 0, 0, 0, 10);
        vecs[0].exp[0] = pk(-9, -8, -7, -6, -5, -4, -3, -2);
        vecs[0].exp[1] = pk(-10, -10, -10, -10, -10, -10, -10, 0);

        vecs[1].mode = 2'd2; vecs[1].n = 1; vecs[1].bp = 0;
        vecs[1].din[0] = pk(-128, 127, -5, -3, 0, 0, -1, -128);
        vecs[1].exp[0] = pk(-128, 0, -2, 0, 0, 0, 0, -127);

        vecs[2].mode = 2'd1; vecs[2].n = 1; vecs[2].bp = 0;
        vecs[2].din[0] = pk(-128, -128, -128, -128, -128, -128, -128, -128);
        vecs[2].exp[0] = 64'd0;

        vecs[3].mode = 2'd1; vecs[3].n = 3; vecs[3].bp = 0;
        vecs[3].din[0] = pk(10, 20, 30, 40, -50, -60, -70, -80);
        vecs[3].din[1] = pk(50, 0, 0, 0, -100, -100, -100, -90);
        vecs[3].din[2] = pk(0, 0, 0, 0, -128, -128, -128, -128);
        vecs[3].exp[0] = pk(-40, -30, -20, -10, 0, -10, -20, -30);
        vecs[3].exp[1] = pk(0, -50, -50, -50, -50, -50, -50, -40);
        vecs[3].exp[2] = pk(-50, -50, -50, -50, -78, -78, -78, -78);

        vecs[4].mode = 2'd3; vecs[4].n = 1; vecs[4].bp = 0;
        vecs[4].din[0] = pk(-1, -2, -3, -4, -5, -6, -7, 100);
        vecs[4].exp[0] = pk(-101, -102, -103, -104, -105, -106, -107, 0);

        vecs[5].mode = 2'd2; vecs[5].n = 4; vecs[5].bp = 1;
        vecs[5].din[0] = pk(1, 2, 3, 4, 5, 6, 7, 8);
        vecs[5].din[1] = pk(8, 1, 7, 2, 6, 3, 5, 4);
        vecs[5].din[2] = pk(-1, -1, -1, -1, -1, -1, -1, -1);
        vecs[5].din[3] = pk(0, 0, 0, 0, 0, 0, 0, 0);
        vecs[5].exp[0] = pk(-7, -6, -4, -3, -1, 0, -1, 0);
        vecs[5].exp[1] = pk(0, -7, 0, -5, 0, -3, -3, -4);
        vecs[5].exp[2] = pk(-9, -9, -8, -8, -7, -7, -9, -9);
        vecs[5].exp[3] = pk(-8, -8, -7, -7, -6, -6, -8, -8);

        rst_n = 1'b0; seg_mode = 2'd0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_last",  64'(out_last),  64'd0);
        chk("rst out_data",  out_data,       64'd0);
        chk("rst row_err",   64'(row_err),   64'd0);
        chk("rst in_ready",  64'(in_ready),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 6; v++) begin
            send_row(vecs[v].mode, vecs[v].n, vecs[v].din, 1'b1);
            recv_row($sformatf("v%0d", v), vecs[v].n, vecs[v].exp, vecs[v].bp);
        end
        chk("no row_err on normal rows", 64'(rerr_cnt), 64'd0);

        // Truncation: 16 beats without in_last
        for (int k = 0; k < 16; k++) begin
            tb_in[k]  = {8{8'(k)}};
            tb_exp[k] = {8{8'(k - 15)}};
        end
        snap = rerr_cnt;
        send_row(2'd0, 16, tb_in, 1'b0);
        chk("trunc row_err pulse", 64'(row_err), 64'd1);
        recv_row("trunc", 16, tb_exp, 1'b0);
        chk("trunc row_err count", 64'(rerr_cnt - snap), 64'd1);
        send_row(vecs[2].mode, vecs[2].n, vecs[2].din, 1'b1);
        recv_row("after_trunc", vecs[2].n, vecs[2].exp, 1'b0);

        // Reset during DRAIN after one of three output beats
        snap = rerr_cnt;
        send_row(vecs[3].mode, vecs[3].n, vecs[3].din, 1'b1);
        chk("rstd b0 data", out_data, vecs[3].exp[0]);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("rstd b1 data", out_data, vecs[3].exp[1]);
        rst_n = 1'b0;
        #1;
        chk("rstd out_valid", 64'(out_valid), 64'd0);
        chk("rstd out_last",  64'(out_last),  64'd0);
        chk("rstd out_data",  out_data,       64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstd in_ready", 64'(in_ready), 64'd1);
        chk("rstd valid idle", 64'(out_valid), 64'd0);
        send_row(vecs[0].mode, vecs[0].n, vecs[0].din, 1'b1);
        recv_row("after_rst", vecs[0].n, vecs[0].exp, 1'b0);
        chk("rstd no row_err", 64'(rerr_cnt - snap), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
